// File: rtl/fsoc_trace_pkg.sv
// fsoc_trace_pkg: register map, STATUS bit positions and trace entry layout
package fsoc_trace_pkg;
  localparam logic [1:0] TR_STATUS = 2'd0;
  localparam logic [1:0] TR_INSTR  = 2'd1;
  localparam logic [1:0] TR_STAMP  = 2'd2;
  localparam logic [1:0] TR_CTRL   = 2'd3;
  localparam int ST_EMPTY = 16;
  localparam int ST_FULL  = 17;
  localparam int ST_OVF   = 18;
  localparam int ST_GATE  = 19;
  localparam int ST_SWEN  = 20;
  // Stamps narrower than this are stored zero-extended.
  localparam int TR_STAMP_MAXW = 32;
  typedef struct packed {
    logic [31:0]              instr;
    logic [TR_STAMP_MAXW-1:0] stamp;
  } trace_entry_t;
endpackage

// File: rtl/fsoc_trace_fifo.sv
// fsoc_trace_fifo: single-clock FIFO with flush and combinational head
module fsoc_trace_fifo
  import fsoc_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic         clk_i,
  input  logic         rst_in,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  trace_entry_t din,
  output trace_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  trace_entry_t mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  logic [CW-1:0] count_n;
  // A pop frees the slot, so a full FIFO still accepts a push in the same cycle.
  assign do_push = push & ~flush & (~full | pop);
  assign do_pop  = pop & ~flush & ~empty;
  assign count_n = count + CW'(do_push) - CW'(do_pop);
  assign head    = mem[rptr];
  assign empty   = count == '0;
  always_ff @(posedge clk_i) if (do_push) mem[wptr] <= din;
  always_ff @(posedge clk_i) begin
    if (!rst_in || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
    end else begin
      wptr  <= do_push ? wptr + AW'(1) : wptr;
      rptr  <= do_pop ? rptr + AW'(1) : rptr;
      count <= count_n;
      full  <= count_n == CW'(DEPTH);
    end
  end
endmodule

// File: rtl/fsoc_trace_buf.sv
// fsoc_trace_buf: gated instruction-fetch trace capture drained over a Wishbone slave
module fsoc_trace_buf
  import fsoc_trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int STAMPW = 32
) (
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic        imem_stb_i,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_dat_i,
  input  logic        gate_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        full_o,
  output logic        ovf_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic gate_r, sw_en;
  logic [STAMPW-1:0] stamp;
  logic [CW-1:0] count;
  logic full, empty;
  trace_entry_t head, din;
  logic req, rd, wr, push, pop, flush;
  logic [31:0] status, rdata;
  logic unused_wdat;
  assign unused_wdat = ^wb_dat_i[31:2];
  assign req   = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign rd    = req & ~wb_we_i;
  assign wr    = req & wb_we_i;
  // The window stays open through the cycle in which the gate falls.
  assign push  = imem_stb_i & imem_ack_i & (gate_i | gate_r) & sw_en;
  assign pop   = rd & (wb_adr_i == TR_STAMP) & ~empty;
  assign flush = wr & (wb_adr_i == TR_CTRL) & wb_dat_i[0];
  assign din   = '{instr: imem_dat_i, stamp: TR_STAMP_MAXW'(stamp)};
  assign full_o = full;
  always_comb begin
    status           = 32'(count);
    status[ST_EMPTY] = empty;
    status[ST_FULL]  = full;
    status[ST_OVF]   = ovf_o;
    status[ST_GATE]  = gate_i;
    status[ST_SWEN]  = sw_en;
    rdata = wb_adr_i == TR_STATUS ? status :
            wb_adr_i == TR_INSTR  ? (empty ? '0 : head.instr) :
            wb_adr_i == TR_STAMP  ? (empty ? '0 : head.stamp) :
            {30'b0, sw_en, 1'b0};
  end
  fsoc_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i (clk_i),
    .rst_in(rst_in),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (din),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      gate_r   <= 1'b0;
      sw_en    <= 1'b0;
      stamp    <= '0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      ovf_o    <= 1'b0;
    end else begin
      gate_r   <= gate_i;
      stamp    <= (~gate_r & gate_i) ? '0 : stamp + STAMPW'(1);
      wb_ack_o <= req;
      wb_dat_o <= rd ? rdata : '0;
      sw_en    <= (wr && wb_adr_i == TR_CTRL) ? wb_dat_i[1] : sw_en;
      ovf_o    <= flush ? 1'b0 : ovf_o | (push & full & ~pop);
    end
  end
endmodule

// File: tb/tb_fsoc_trace_buf.sv
// tb_fsoc_trace_buf: directed and random checks against a queue-based trace model
module tb_fsoc_trace_buf;
  localparam int DEPTH = 16;
  typedef struct packed { logic [31:0] i; logic [31:0] s; } ent_t;
  logic clk = 0, rst_n = 0, imem_stb = 0, imem_ack = 0, gate = 0;
  logic wb_cyc = 0, wb_stb = 0, wb_we = 0;
  logic [1:0] wb_adr = 0;
  logic [31:0] imem_dat = 0, wb_wdat = 0, rdat;
  logic ack, full, ovf;
  int checks = 0, errors = 0;
  ent_t q[$];
  bit m_sw, m_ovf, m_gr, m_ack;
  logic [31:0] m_dat;
  int unsigned cyc_n = 0, edge_n = 0;

  always #5 clk = ~clk;

  fsoc_trace_buf #(.DEPTH(DEPTH), .STAMPW(32)) dut (
    .clk_i(clk), .rst_in(rst_n), .imem_stb_i(imem_stb), .imem_ack_i(imem_ack),
    .imem_dat_i(imem_dat), .gate_i(gate), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb),
    .wb_we_i(wb_we), .wb_adr_i(wb_adr), .wb_dat_i(wb_wdat), .wb_dat_o(rdat),
    .wb_ack_o(ack), .full_o(full), .ovf_o(ovf)
  );

  // Reference model: stamp = cycles elapsed since the last gate rise (or reset) minus one.
  task automatic tick();
    logic [31:0] rv;
    bit req, rd, wr;
    ent_t e;
    @(posedge clk);
    if (!rst_n) begin
      q.delete(); m_sw = 0; m_ovf = 0; m_gr = 0; m_ack = 0; m_dat = 0; edge_n = cyc_n;
    end else begin
      req = wb_cyc & wb_stb & !m_ack;
      rd = req & !wb_we;
      wr = req & wb_we;
      case (wb_adr)
        2'd0: rv = {11'b0, m_sw, gate, m_ovf, q.size() == DEPTH, q.size() == 0, 16'(q.size())};
        2'd1: rv = q.size() > 0 ? q[0].i : 32'h0;
        2'd2: rv = q.size() > 0 ? q[0].s : 32'h0;
        default: rv = {30'b0, m_sw, 1'b0};
      endcase
      e.i = imem_dat;
      e.s = cyc_n - edge_n - 1;
      if (wr && wb_adr == 2'd3 && wb_wdat[0]) begin
        q.delete(); m_ovf = 0;
      end else begin
        if (rd && wb_adr == 2'd2 && q.size() > 0) void'(q.pop_front());
        if (imem_stb && imem_ack && (gate || m_gr) && m_sw) begin
          if (q.size() < DEPTH) q.push_back(e); else m_ovf = 1;
        end
      end
      if (wr && wb_adr == 2'd3) m_sw = wb_wdat[1];
      if (gate && !m_gr) edge_n = cyc_n;
      m_gr = gate;
      m_ack = req;
      m_dat = rd ? rv : 32'h0;
    end
    cyc_n++;
    #1;
  endtask

  task automatic wb(input logic w, input logic [1:0] a, input logic [31:0] d,
                    output logic [31:0] r, output logic k, output logic [31:0] x);
    wb_cyc = 1; wb_stb = 1; wb_we = w; wb_adr = a; wb_wdat = d;
    tick();
    r = rdat; k = ack; x = m_dat;
    wb_cyc = 0; wb_stb = 0; wb_we = 0;
    tick();
  endtask

  task automatic fetch(input logic [31:0] d);
    imem_stb = 1; imem_ack = 1; imem_dat = d;
    tick();
    imem_stb = 0; imem_ack = 0;
  endtask

  task automatic test_reset();
    logic [31:0] r, x;
    logic k;
    rst_n = 0;
    tick(); tick();
    checks++;
    if (ack !== 1'b0 || rdat !== 32'h0 || full !== 1'b0 || ovf !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got ack=%b dat=%h full=%b ovf=%b, want all 0", ack, rdat, full, ovf);
    end
    rst_n = 1;
    tick();
    wb(0, 2'd0, 0, r, k, x);
    checks++;
    if (k !== 1'b1 || r !== 32'h0001_0000) begin
      errors++; $display("FAIL reset_status: got ack=%b dat=%h, want ack=1 dat=00010000", k, r);
    end
  endtask

  task automatic test_stamps();
    logic [31:0] r, x;
    logic k;
    logic [31:0] exp_s [3] = '{32'd0, 32'd3, 32'd8};
    wb(1, 2'd3, 32'h2, r, k, x);
    gate = 1;
    tick();
    for (int c = 1; c <= 9; c++) begin
      if (c == 1 || c == 4 || c == 9) fetch($urandom); else tick();
    end
    gate = 0;
    wb(0, 2'd0, 0, r, k, x);
    checks++;
    if (k !== 1'b1 || r[15:0] !== 16'd3 || r !== x) begin
      errors++; $display("FAIL stamps_count: got ack=%b dat=%h, want count=3 dat=%h", k, r, x);
    end
    for (int j = 0; j < 3; j++) begin
      wb(0, 2'd2, 0, r, k, x);
      checks++;
      if (k !== 1'b1 || r !== exp_s[j]) begin
        errors++; $display("FAIL stamp_%0d: got ack=%b dat=%0d, want %0d", j, k, r, exp_s[j]);
      end
    end
  endtask

  task automatic test_sw_off();
    logic [31:0] r, x;
    logic k;
    wb(1, 2'd3, 32'h1, r, k, x);
    gate = 1;
    for (int j = 0; j < 5; j++) fetch($urandom);
    gate = 0;
    wb(0, 2'd0, 0, r, k, x);
    checks++;
    if (r[15:0] !== 16'd0 || r[18] !== 1'b0 || ovf !== 1'b0 || r !== x) begin
      errors++; $display("FAIL sw_off: got status=%h ovf=%b, want count=0 ovf=0 status=%h", r, ovf, x);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] r, x;
    logic k;
    wb(1, 2'd3, 32'h3, r, k, x);
    gate = 1;
    fetch(32'h0000_0013);
    for (int j = 0; j < 16; j++) fetch($urandom);
    checks++;
    if (full !== 1'b1 || ovf !== 1'b1) begin
      errors++; $display("FAIL overflow_flags: got full=%b ovf=%b, want 1 1", full, ovf);
    end
    wb(0, 2'd0, 0, r, k, x);
    checks++;
    if (r[15:0] !== 16'd16 || r[17] !== 1'b1 || r !== x) begin
      errors++; $display("FAIL overflow_count: got status=%h, want count=16 status=%h", r, x);
    end
    wb(0, 2'd1, 0, r, k, x);
    checks++;
    if (r !== 32'h0000_0013) begin
      errors++; $display("FAIL overflow_head: got %h, want 00000013", r);
    end
  endtask

  task automatic test_full_pushpop();
    logic [31:0] r, x, nw;
    logic k;
    nw = $urandom | 32'h1;
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 2'd2;
    imem_stb = 1; imem_ack = 1; imem_dat = nw;
    tick();
    checks++;
    if (ack !== 1'b1 || rdat !== m_dat) begin
      errors++; $display("FAIL pushpop_read: got ack=%b dat=%h, want ack=1 dat=%h", ack, rdat, m_dat);
    end
    imem_stb = 0; imem_ack = 0; wb_cyc = 0; wb_stb = 0;
    tick();
    gate = 0;
    wb(0, 2'd0, 0, r, k, x);
    checks++;
    if (r[15:0] !== 16'd16 || r[18] !== 1'b1 || r !== x) begin
      errors++; $display("FAIL pushpop_status: got %h, want count=16 ovf=1 status=%h", r, x);
    end
    for (int j = 0; j < DEPTH; j++) begin
      wb(0, 2'd1, 0, r, k, x);
      checks++;
      if (r !== x || (j == DEPTH - 1 && r !== nw)) begin
        errors++; $display("FAIL drain_instr_%0d: got %h, want %h", j, r, j == DEPTH - 1 ? nw : x);
      end
      wb(0, 2'd2, 0, r, k, x);
      checks++;
      if (r !== x) begin
        errors++; $display("FAIL drain_stamp_%0d: got %h, want %h", j, r, x);
      end
    end
  endtask

  task automatic test_gate_fall();
    logic [31:0] r, x, a;
    logic k;
    a = $urandom;
    wb(1, 2'd3, 32'h3, r, k, x);
    gate = 1;
    tick(); tick();
    gate = 0;
    fetch(a);
    fetch(~a);
    wb(0, 2'd0, 0, r, k, x);
    checks++;
    if (r[15:0] !== 16'd1 || r !== x) begin
      errors++; $display("FAIL gate_fall_count: got %h, want count=1 status=%h", r, x);
    end
    wb(0, 2'd1, 0, r, k, x);
    checks++;
    if (r !== a) begin
      errors++; $display("FAIL gate_fall_head: got %h, want %h", r, a);
    end
  endtask

  task automatic test_empty_flush_reset();
    logic [31:0] r, x;
    logic k;
    wb(1, 2'd3, 32'h3, r, k, x);
    wb(0, 2'd2, 0, r, k, x);
    checks++;
    if (k !== 1'b1 || r !== 32'h0) begin
      errors++; $display("FAIL empty_stamp: got ack=%b dat=%h, want ack=1 dat=0", k, r);
    end
    wb(0, 2'd0, 0, r, k, x);
    checks++;
    if (r[15:0] !== 16'd0 || r[16] !== 1'b1) begin
      errors++; $display("FAIL empty_count: got %h, want count=0 empty=1", r);
    end
    gate = 1;
    for (int j = 0; j < 3; j++) fetch($urandom);
    gate = 0;
    wb(1, 2'd3, 32'h3, r, k, x);
    wb(0, 2'd0, 0, r, k, x);
    checks++;
    if (r[15:0] !== 16'd0 || r[18] !== 1'b0 || r[20] !== 1'b1 || r !== x) begin
      errors++; $display("FAIL flush_status: got %h, want count=0 ovf=0 sw_en=1 status=%h", r, x);
    end
    wb(0, 2'd3, 0, r, k, x);
    checks++;
    if (r !== 32'h2) begin
      errors++; $display("FAIL ctrl_read: got %h, want 00000002", r);
    end
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 2'd0; rst_n = 0;
    tick();
    checks++;
    if (ack !== 1'b0 || rdat !== 32'h0) begin
      errors++; $display("FAIL reset_mid_read: got ack=%b dat=%h, want 0 0", ack, rdat);
    end
    wb_cyc = 0; wb_stb = 0; rst_n = 1;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom % 500) != 0;
      if ($urandom % 25 == 0) gate = ~gate;
      imem_stb = $urandom % 2;
      imem_ack = $urandom % 2;
      imem_dat = $urandom;
      wb_cyc = $urandom % 2;
      wb_stb = $urandom % 4 != 0;
      wb_we = $urandom % 5 == 0;
      wb_adr = ($urandom % 2) ? 2'd2 : 2'($urandom);
      wb_wdat = $urandom;
      wb_wdat[1] = $urandom % 4 != 0;
      wb_wdat[0] = $urandom % 6 == 0;
      tick();
      checks++;
      if (ack !== m_ack || rdat !== m_dat) begin
        errors++; $display("FAIL rand_wb cycle %0d: got ack=%b dat=%h, want ack=%b dat=%h", c, ack, rdat, m_ack, m_dat);
      end
      checks++;
      if (full !== (q.size() == DEPTH) || ovf !== m_ovf) begin
        errors++; $display("FAIL rand_flags cycle %0d: got full=%b ovf=%b, want full=%b ovf=%b", c, full, ovf, q.size() == DEPTH, m_ovf);
      end
    end
    rst_n = 1; wb_cyc = 0; wb_stb = 0; imem_stb = 0; imem_ack = 0; gate = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_stamps();
    test_sw_off();
    test_overflow();
    test_full_pushpop();
    test_gate_fall();
    test_empty_flush_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
